// File: rtl/bdi_compressor.sv
// rtl/bdi_compressor.sv - Base-Delta-Immediate cache line compressor
//
// Takes one 256-bit line and tries the eight BDI encodings, one per cycle
// (CoN = cnt). It keeps the smallest eligible encoding, with ties going to
// the lower CoN. It then packs that encoding into the 260-bit word the
// decompressor reads, and holds it until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   line_in is valid
//   in_ready   a line can be accepted (IDLE only)
//   line_in    uncompressed line, word k at [k*W +: W]
//   out_valid  comp_out / comp_bits are valid
//   out_ready  consumer accepts comp_out
//   comp_out   compressed word, [3:0] = CoN, unused bits zero
//   comp_bits  number of meaningful bits in comp_out (4..260)

module bdi_compressor (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] line_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [259:0] comp_out,
  output logic [8:0]   comp_bits
);

  typedef enum logic [1:0] {IDLE, SCAN, PACK, HOLD} state_t;

  state_t       state;
  logic [2:0]   cnt;
  logic [255:0] line_q;
  logic [3:0]   best_con;
  logic [8:0]   best_size;

  logic [63:0]  w64 [4];
  logic [31:0]  w32 [8];
  logic [15:0]  w16 [16];

  logic         scan_elig;
  logic [8:0]   scan_size;
  logic [259:0] pk;

  // Delta width n for the base/delta encodings.
  function automatic int con_n(input logic [2:0] c);
    case (c)
      3'd3, 3'd6: return 16;
      3'd4:       return 32;
      default:    return 8;
    endcase
  endfunction

  // Delta of word w against base b at width wbits with n-bit delta.
  // Returns {fit, flag, mag}. When the word does not fit, mag carries the
  // full forward difference d, which is what the base4 encodings store for a
  // status-0 word.
  function automatic logic [65:0] bdelta(input logic [63:0] w,
                                         input logic [63:0] b,
                                         input int          wbits,
                                         input int          n);
    logic [63:0] wmask;
    logic [63:0] nmask;
    logic [63:0] d;
    logic [63:0] e;
    wmask = (wbits == 64) ? '1 : ((64'd1 << wbits) - 64'd1);
    nmask = (64'd1 << n) - 64'd1;
    d = (w - b) & wmask;
    e = (b - w) & wmask;
    if ((d & ~nmask) == 64'd0)      return {1'b1, 1'b1, d};
    else if ((e & ~nmask) == 64'd0) return {1'b1, 1'b0, e};
    else                            return {1'b0, 1'b0, d};
  endfunction

  assign in_ready = (state == IDLE);

  always_comb begin
    for (int i = 0; i < 4; i++)  w64[i] = line_q[i*64 +: 64];
    for (int i = 0; i < 8; i++)  w32[i] = line_q[i*32 +: 32];
    for (int i = 0; i < 16; i++) w16[i] = line_q[i*16 +: 16];
  end

  // Eligibility and size of encoding CoN = cnt.
  logic [65:0] r_s;
  int          k_s;
  int          n_s;
  always_comb begin
    scan_elig = 1'b0;
    scan_size = 9'd260;
    r_s       = '0;
    k_s       = 0;
    n_s       = con_n(cnt);
    case (cnt)
      3'd0: begin
        scan_elig = (line_q == 256'd0);
        scan_size = 9'd4;
      end
      3'd1: begin
        scan_elig = 1'b1;
        for (int i = 1; i < 4; i++)
          if (w64[i] != w64[0]) scan_elig = 1'b0;
        scan_size = 9'd68;
      end
      3'd2, 3'd3, 3'd4: begin
        scan_elig = 1'b1;
        for (int i = 1; i < 4; i++) begin
          r_s = bdelta(w64[i], w64[0], 64, n_s);
          if (!r_s[65]) scan_elig = 1'b0;
        end
        scan_size = 9'(72 + 4 * n_s);
      end
      3'd5, 3'd6: begin
        // k counts words that fall back to a full 32-bit delta.
        for (int i = 1; i < 8; i++) begin
          r_s = bdelta({32'd0, w32[i]}, {32'd0, w32[0]}, 32, n_s);
          if (!r_s[65]) k_s++;
        end
        if (cnt == 3'd5) begin
          scan_elig = (k_s <= 6);
          scan_size = 9'(116 + 24 * k_s);
        end else begin
          scan_elig = (k_s <= 5);
          scan_size = 9'(180 + 16 * k_s);
        end
      end
      default: begin
        scan_elig = 1'b1;
        for (int i = 1; i < 16; i++) begin
          r_s = bdelta({48'd0, w16[i]}, {48'd0, w16[0]}, 16, 8);
          if (!r_s[65]) scan_elig = 1'b0;
        end
        scan_size = 9'd164;
      end
    endcase
  end

  // Pack the winning encoding. Only eligible encodings ever reach here.
  logic [65:0] r_p;
  int          n_p;
  int          pos;
  always_comb begin
    pk  = '0;
    r_p = '0;
    n_p = con_n(best_con[2:0]);
    pos = 52;
    case (best_con)
      4'd0: ;
      4'd1: pk[67:4] = w64[0];
      4'd2, 4'd3, 4'd4: begin
        pk[71:8] = w64[0];
        for (int i = 0; i < 4; i++) begin
          r_p = bdelta(w64[i], w64[0], 64, n_p);
          pk[4+i] = r_p[64];
          pk = pk | (260'(r_p[63:0]) << (72 + i * n_p));
        end
      end
      4'd5, 4'd6: begin
        pk[51:20] = w32[0];
        for (int i = 0; i < 8; i++) begin
          r_p = bdelta({32'd0, w32[i]}, {32'd0, w32[0]}, 32, n_p);
          pk = pk | (260'(r_p[31:0]) << pos);
          if (r_p[65]) begin
            pk[4+i]  = r_p[64];
            pk[12+i] = 1'b1;
            pos      = pos + n_p;
          end else begin
            pk[4+i]  = 1'b1;
            pos      = pos + 32;
          end
        end
      end
      4'd7: begin
        pk[35:20] = w16[0];
        for (int i = 1; i < 16; i++) begin
          r_p = bdelta({48'd0, w16[i]}, {48'd0, w16[0]}, 16, 8);
          pk[3+i] = r_p[64];
          pk = pk | (260'(r_p[7:0]) << (36 + 8 * i));
        end
      end
      default: pk[259:4] = line_q;
    endcase
    pk[3:0] = best_con;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      line_q    <= '0;
      best_con  <= 4'd15;
      best_size <= 9'd260;
      out_valid <= 1'b0;
      comp_out  <= '0;
      comp_bits <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            line_q    <= line_in;
            best_con  <= 4'd15;
            best_size <= 9'd260;
            cnt       <= 3'd0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          // Strictly-smaller keeps the lower CoN on ties, since the scan ascends.
          if (scan_elig && (scan_size < best_size)) begin
            best_con  <= {1'b0, cnt};
            best_size <= scan_size;
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= PACK;
        end
        PACK: begin
          comp_out  <= pk;
          comp_bits <= best_size;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bdi_compressor.md
# bdi_compressor

Base-Delta-Immediate line compressor. It is the write-side counterpart of the BDI dynamic-base decompressor. It accepts one 256-bit cache line and scans the eight BDI encodings, one per cycle. It then packs the smallest legal encoding into the 260-bit compressed word that the decompressor consumes, and holds the result until the downstream side accepts it.

## Interface
Parameters: none (line width 256 and compressed width 260 are fixed by the format).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  line_in is valid
- in_ready  out  1  block can accept a line (high only in IDLE)
- line_in  in  256  uncompressed line; word k occupies bits [k*W +: W]
- out_valid  out  1  comp_out/comp_bits are valid
- out_ready  in  1  consumer accepts comp_out
- comp_out  out  260  compressed word; [3:0] = CoN
- comp_bits  out  9  meaningful bits in comp_out (4..260)

## Operation
- Delta rule for every base/delta encoding (width W, delta width n):
  - d = (w − base) mod 2^W. If d < 2^n, flag = 1 and mag = d.
  - Otherwise e = (base − w) mod 2^W. If e < 2^n, flag = 0 and mag = e.
  - Otherwise the word does not fit.
  - Decoder identity: flag 1 → base + mag; flag 0 → base − mag.
- The base is always word 0 at the relevant width. Word 0 is encoded with flag 1 and mag 0.
- Encodings and exact layout. All unused comp_out bits must be 0.
  - CoN 0: all 256 bits zero. Size 4.
  - CoN 1: all four 64-bit words equal. [67:4] = word0. Size 68.
  - CoN 2/3/4: base8 with delta of 1, 2 or 4 bytes (n = 8/16/32).
    - flag8[i] at [4+i].
    - base at [71:8].
    - mag_i at [72 + i*n +: n].
    - Eligible only if all four words fit. Sizes 104/136/200.
  - CoN 5/6: base4 with dynamic delta of 1 or 2 bytes (n = 8/16).
    - flag4[i] at [4+i]; status[i] at [12+i]. status = 1 means an n-bit delta, 0 means a full 32-bit delta (flag 1, mag = d).
    - base at [51:20].
    - Deltas are packed back-to-back from bit 52 in word order.
    - Eligible only if the packed payload is ≤ 208 bits, i.e. k ≤ 6 (CoN 5) or k ≤ 5 (CoN 6), where k = number of words with status 0.
    - Size is 116+24k (CoN 5) or 180+16k (CoN 6).
  - CoN 7: base2 with 1-byte delta over 16 16-bit words.
    - flag2[i−1] at [3+i] for word i = 1..15; bit [19] = 0.
    - base at [35:20]; [43:36] = 0.
    - mag_i at [36+8i +: 8].
    - Eligible only if all 15 deltas fit. Size 164.
  - CoN 15: [259:4] = line. Size 260. Always eligible.
- Selection: among eligible encodings, pick the minimum size. On a tie, pick the lower CoN. CoN 15 is chosen only if nothing else is eligible.
- FSM:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture the line, clear best = {15, 260}, set cnt = 0, go to SCAN.
  - SCAN: evaluate CoN = cnt. If it is eligible and strictly smaller than best, update best. cnt++. After cnt = 7, go to PACK.
  - PACK: build comp_out from best, register comp_out, comp_bits and out_valid = 1, go to HOLD.
  - HOLD: hold all outputs stable. On out_valid & out_ready, drop out_valid and go to IDLE.
- in_valid is ignored outside IDLE. Input is never accepted while output is pending.

## Timing
- Reset (async assert, sync-release use): state = IDLE, out_valid = 0, comp_out = 0, comp_bits = 0, cnt = 0, in_ready = 1.
- Latency: accept at edge E0, SCAN at edges E1..E8, PACK at E9. out_valid is high after E9 (9 cycles).
- comp_out and comp_bits are stable whenever out_valid = 1 and only change in PACK.
- Output handshake at edge Ex → in_ready = 1 after Ex. The next accept is possible at Ex+1. Minimum period is 11 cycles per line.
- If out_ready is already high at PACK, the transfer happens at E10.
- Reset mid-SCAN, mid-PACK or mid-HOLD aborts the line. No output is produced for it.
- All arithmetic is modulo the word width. Wrap-around, e.g. base 0x0000 and word 0xFFFF, fits 1 byte with flag 0, mag 1.

## Test plan
- All-zero line → CoN 0, comp_out = 260'h0, comp_bits = 4. out_valid rises 9 cycles after accept.
- Four words 64'h123456789ABCDEF0 → CoN 1, [67:4] = that value, all other bits 0, comp_bits = 68.
- Base B = 64'h1000000000000000; words B, B+5, B−3, B+0x80 → CoN 2, flag8 = 4'b1011, deltas 00/05/03/80 at [79:72]..[103:96], comp_bits = 104.
- 16-bit words 0x4000+i (i = 0..15) → CoN 7, flag2 = 16'h7FFF, base 0x4000, mag_i = i, comp_bits = 164.
- Random incompressible line, out_ready held low for 5 cycles after out_valid → CoN 15, [259:4] = line, comp_bits = 260. comp_out is stable and in_ready = 0 throughout; transfer occurs when out_ready rises.
- rst_n pulsed low during SCAN cycle 4 → out_valid stays 0, in_ready = 1 after release. The next line compresses correctly.
